uart_receiver: RTL
==================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 P_UART_DATA_WIDTH, `UART_DATA_WIDTH, data bits per frame (5..9).
REQ-002 P_UART_STOP_WIDTH, `UART_STOP_WIDTH, stop bits per frame (1..2).
REQ-003 P_UART_CHECK, `UART_CHECK, parity mode: 0 none, 1 odd, 2 even.
REQ-004 i_u_clk  in  1  bit clock; one UART bit per cycle, same clock as the transmitter.
REQ-005 i_u_rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-006 i_uart_rx  in  1  serial line; idle high, asynchronous to i_u_clk.
REQ-007 o_uart_rx_data  out  P_UART_DATA_WIDTH  received word, LSB first on the line.
REQ-008 o_uart_rx_valid  out  1  word available; held until accepted.
REQ-009 i_uart_rx_ready  in  1  consumer accepts word when high with valid.
REQ-010 o_uart_rx_perr  out  1  parity error flag qualifying o_uart_rx_data.
REQ-011 o_uart_rx_ferr  out  1  framing error flag (a stop bit sampled low) qualifying o_uart_rx_data.
REQ-012 o_uart_rx_overrun  out  1  one-cycle pulse: a completed frame was dropped.

Function
REQ-013 i_uart_rx SHALL pass through a 2-flop synchronizer; the FSM sees only the synchronized bit (rx_s), 2 cycles after the line.
REQ-014 FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: rx_s==0 SHALL be taken as the start bit -> DATA, bit counter cleared.
REQ-016 DATA: each cycle SHALL shift rx_s into the MSB of the shift register (right shift); after P_UART_DATA_WIDTH cycles -> PARITY if P_UART_CHECK>0, else -> STOP.
REQ-017 PARITY: one cycle.
  - Mode 1 (odd): perr SHALL be set when XOR(data, rx_s)==0.
  - Mode 2 (even): perr SHALL be set when XOR(data, rx_s)==1.
  - Then -> STOP.
REQ-018 STOP: P_UART_STOP_WIDTH cycles; any rx_s==0 SHALL set ferr. The cycle after the last stop bit -> IDLE.
REQ-019 On the last stop cycle, if the holding register is free (valid==0, or valid&&ready that cycle), the holding register SHALL load word, perr and ferr, and valid SHALL be 1 next cycle.
REQ-020 On the last stop cycle, if valid==1 and ready==0, the new frame SHALL be dropped, the held word kept unchanged, and o_uart_rx_overrun pulsed for one cycle.
REQ-021 valid SHALL clear the cycle after valid&&ready, unless a load occurs that same cycle (REQ-019), in which case valid stays 1 with the new word.
REQ-022 Frames with perr or ferr SHALL still be delivered, with the flags set.
REQ-023 Back-to-back frames: rx_s==0 in the first IDLE cycle after STOP SHALL start a new frame with no gap required.
REQ-024 Latency: valid SHALL rise 3 cycles after the last stop bit appears on i_uart_rx.
REQ-025 No glitch filtering: a single low sample in IDLE SHALL start a frame.

Reset
REQ-026 While i_u_rst is high at a clock edge:
  - state = IDLE; counters = 0.
  - synchronizer flops = 1.
  - o_uart_rx_data = 0; valid, perr, ferr, overrun = 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no output; reception resumes on the next start bit after reset.

Structure
REQ-028 Data width, stop width and parity mode defaults SHALL come from the shared Uart_Defines.v. Parity-mode encodings (NONE=0, ODD=1, EVEN=2) SHALL be added there and shared with the transmitter.
REQ-029 The synchronizer SHALL be a sub-module, uart_sync (2 flops, reset value 1).
REQ-030 The bit counter SHALL be sized $clog2(P_UART_DATA_WIDTH+1) bits and the stop counter 2 bits.

Verification
REQ-031 8N1, ready=1, send 0xA5 -> one valid with data 0xA5, perr=0, ferr=0.
REQ-032 8E1, send 0x3C with parity 0 -> perr=0. Repeat with parity 1 -> data 0x3C, perr=1.
REQ-033 8N1, 0x5A with stop bit driven 0 -> data 0x5A, ferr=1. Next frame 0x01 is received clean.
REQ-034 ready=0, send 0x11 then 0x22 back-to-back -> data stays 0x11, overrun pulses once. After ready=1, exactly one transfer of 0x11.
REQ-035 Assert reset at data bit 4 of 0xFF, then send 0x81 -> only 0x81 is delivered.
REQ-036 Loopback from the transmitter, 8O2, 256 random words -> all words match in order, no error flags.

Source files
------------

// File: rtl/uart_receiver_pkg.sv
// Shared UART receiver types and defaults. The `UART_* macros are also the
// transmitter's defaults, so both sides agree on frame shape and parity code.
`ifndef UART_DATA_WIDTH
`define UART_DATA_WIDTH 8
`endif
`ifndef UART_STOP_WIDTH
`define UART_STOP_WIDTH 1
`endif
`ifndef UART_CHECK_NONE
`define UART_CHECK_NONE 0
`endif
`ifndef UART_CHECK_ODD
`define UART_CHECK_ODD 1
`endif
`ifndef UART_CHECK_EVEN
`define UART_CHECK_EVEN 2
`endif
`ifndef UART_CHECK
`define UART_CHECK `UART_CHECK_NONE
`endif

package uart_receiver_pkg;

  localparam int unsigned CHECK_NONE = `UART_CHECK_NONE;
  localparam int unsigned CHECK_ODD  = `UART_CHECK_ODD;
  localparam int unsigned CHECK_EVEN = `UART_CHECK_EVEN;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // data_xor is the XOR of all received data bits; par_bit the sampled parity bit.
  function automatic logic parity_err(input int unsigned mode,
                                      input logic data_xor,
                                      input logic par_bit);
    logic err;
    err = 1'b0;
    if (mode == CHECK_ODD)       err = ~(data_xor ^ par_bit);
    else if (mode == CHECK_EVEN) err = data_xor ^ par_bit;
    return err;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle level.
module uart_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, one bit per clock, with a single-word holding register and
// valid/ready hand-off. Parity and framing errors travel with the word.
//
// state  | meaning
// IDLE   | waiting for a low sample (start bit)
// DATA   | shifting data bits in, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling stop bits; last one hands the word off
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int unsigned P_UART_DATA_WIDTH = `UART_DATA_WIDTH,
  parameter int unsigned P_UART_STOP_WIDTH = `UART_STOP_WIDTH,
  parameter int unsigned P_UART_CHECK      = `UART_CHECK
) (
  input  logic                         i_u_clk,
  input  logic                         i_u_rst,
  input  logic                         i_uart_rx,
  output logic [P_UART_DATA_WIDTH-1:0] o_uart_rx_data,
  output logic                         o_uart_rx_valid,
  input  logic                         i_uart_rx_ready,
  output logic                         o_uart_rx_perr,
  output logic                         o_uart_rx_ferr,
  output logic                         o_uart_rx_overrun
);

  localparam int unsigned CNT_W = $clog2(P_UART_DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(P_UART_DATA_WIDTH - 1);
  localparam logic [1:0]       LAST_STOP = 2'(P_UART_STOP_WIDTH - 1);

  logic rx_s;

  uart_sync u_sync (
    .clk_i (i_u_clk),
    .rst_i (i_u_rst),
    .d_i   (i_uart_rx),
    .q_o   (rx_s)
  );

  rx_state_e                  state_q, state_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]                 stop_cnt_q, stop_cnt_d;
  logic [P_UART_DATA_WIDTH-1:0] shift_q, shift_d;
  logic                       perr_q, perr_d;
  logic                       ferr_q, ferr_d;
  logic [P_UART_DATA_WIDTH-1:0] data_q, data_d;
  logic                       valid_q, valid_d;
  logic                       hperr_q, hperr_d;
  logic                       hferr_q, hferr_d;
  logic                       ovr_q, ovr_d;
  logic                       frame_done;

  always_ff @(posedge i_u_clk) begin
    if (i_u_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      hperr_q    <= 1'b0;
      hferr_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      hperr_q    <= hperr_d;
      hferr_q    <= hferr_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = valid_q;
    hperr_d    = hperr_q;
    hferr_d    = hferr_q;
    ovr_d      = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        if (!rx_s) state_d = DATA;
      end
      DATA: begin
        shift_d   = {rx_s, shift_q[P_UART_DATA_WIDTH-1:1]};
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          state_d    = (P_UART_CHECK != CHECK_NONE) ? PARITY : STOP;
          stop_cnt_d = '0;
        end
      end
      PARITY: begin
        perr_d  = parity_err(P_UART_CHECK, ^shift_q, rx_s);
        state_d = STOP;
      end
      STOP: begin
        if (!rx_s) ferr_d = 1'b1;
        if (stop_cnt_q == LAST_STOP) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (valid_q && i_uart_rx_ready) valid_d = 1'b0;

    // The current stop sample is folded in directly; ferr_q lags it by a cycle.
    if (frame_done) begin
      if (!valid_q || i_uart_rx_ready) begin
        data_d  = shift_q;
        hperr_d = perr_q;
        hferr_d = ferr_q | ~rx_s;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign o_uart_rx_data    = data_q;
  assign o_uart_rx_valid   = valid_q;
  assign o_uart_rx_perr    = hperr_q;
  assign o_uart_rx_ferr    = hferr_q;
  assign o_uart_rx_overrun = ovr_q;

endmodule
